// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: MIPS instruction field positions and the NOP word shared by fetch/decode.
package if_id_queue_pkg;
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JIDX_HI  = 25;
  localparam int JIDX_LO  = 0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side push port and decode-side head port of the IF/ID queue.
interface if_id_queue_if #(parameter int CW = 2);
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [27:0] out_jtarget;
  logic [CW-1:0] count;
  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm, out_jtarget, count
  );
  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt, out_rd,
           out_shamt, out_funct, out_imm, out_jtarget, count
  );
endinterface

// File: rtl/if_id_queue_predecode.sv
// if_id_predecode: slices a 32-bit MIPS word into its fields; reused by decode.
module if_id_predecode
  import if_id_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [27:0] jtarget
);
  assign opcode  = instr[OPC_HI:OPC_LO];
  assign rs      = instr[RS_HI:RS_LO];
  assign rt      = instr[RT_HI:RT_LO];
  assign rd      = instr[RD_HI:RD_LO];
  assign shamt   = instr[SHAMT_HI:SHAMT_LO];
  assign funct   = instr[FUNCT_HI:FUNCT_LO];
  assign imm     = instr[IMM_HI:IMM_LO];
  assign jtarget = {instr[JIDX_HI:JIDX_LO], 2'b00};
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: elastic {pc, instr} queue between fetch and decode with flush and predecode.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic reset,
  if_id_queue_if.slave q
);
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop, head_valid;
  logic [31:0]   head_instr;
  assign head_valid  = cnt != '0;
  assign push        = q.in_valid & q.in_ready;
  assign pop         = head_valid & q.out_ready;
  assign head_instr  = head_valid ? instr_mem[rd_ptr] : NOP_WORD;
  assign q.in_ready  = cnt != CW'(DEPTH);
  assign q.out_valid = head_valid;
  assign q.out_pc    = head_valid ? pc_mem[rd_ptr] : '0;
  assign q.out_instr = head_instr;
  assign q.count     = cnt;
  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= q.in_pc;
        instr_mem[wr_ptr] <= q.in_instr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  if_id_predecode u_predecode (
    .instr   (head_instr),
    .opcode  (q.out_opcode),
    .rs      (q.out_rs),
    .rt      (q.out_rt),
    .rd      (q.out_rd),
    .shamt   (q.out_shamt),
    .funct   (q.out_funct),
    .imm     (q.out_imm),
    .jtarget (q.out_jtarget)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and random stimulus against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int CW    = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  if_id_queue_if #(.CW(CW)) bus ();
  if_id_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(bus));
  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] mq [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_outputs();
    logic [31:0] ei, ep;
    int n;
    n  = mq.size();
    ei = (n != 0) ? mq[0][31:0] : 32'h0;
    ep = (n != 0) ? mq[0][63:32] : 32'h0;
    check("out_valid", 64'(bus.out_valid), 64'(n != 0));
    check("in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
    check("count", 64'(bus.count), 64'(n));
    check("out_pc", 64'(bus.out_pc), 64'(ep));
    check("out_instr", 64'(bus.out_instr), 64'(ei));
    check("out_opcode", 64'(bus.out_opcode), 64'(ei[31:26]));
    check("out_rs", 64'(bus.out_rs), 64'(ei[25:21]));
    check("out_rt", 64'(bus.out_rt), 64'(ei[20:16]));
    check("out_rd", 64'(bus.out_rd), 64'(ei[15:11]));
    check("out_shamt", 64'(bus.out_shamt), 64'(ei[10:6]));
    check("out_funct", 64'(bus.out_funct), 64'(ei[5:0]));
    check("out_imm", 64'(bus.out_imm), 64'(ei[15:0]));
    check("out_jtarget", 64'(bus.out_jtarget), 64'({ei[25:0], 2'b00}));
  endtask
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    bit push, pop;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(negedge clk);
    check_outputs();
    push = v && (mq.size() < DEPTH);
    pop  = rdy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({pc, ins});
    end
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    // addi $t0,$zero,5 then consume
    cycle(1, 32'h0, 32'h2008_0005, 0, 0);
    check("t2_rt", 64'(bus.out_rt), 64'd8);
    check("t2_imm", 64'(bus.out_imm), 64'h5);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    // fill, stall the third push, then drain in order
    cycle(1, 32'h0, 32'h1111_0000, 0, 0);
    cycle(1, 32'h4, 32'h2222_0004, 0, 0);
    cycle(1, 32'h8, 32'h3333_0008, 0, 0);
    check("t3_count", 64'(bus.count), 64'd2);
    check("t3_in_ready", 64'(bus.in_ready), 64'd0);
    check("t3_head", 64'(bus.out_pc), 64'h0);
    cycle(1, 32'h8, 32'h3333_0008, 1, 0);
    check("t3_head2", 64'(bus.out_pc), 64'h4);
    cycle(1, 32'h8, 32'h3333_0008, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("t3_empty", 64'(bus.count), 64'd0);
    // j 0x40
    cycle(1, 32'h100, 32'h0800_0010, 0, 0);
    check("t6_opcode", 64'(bus.out_opcode), 64'd2);
    check("t6_jtarget", 64'(bus.out_jtarget), 64'h40);
    cycle(0, 0, 0, 1, 0);
    // steady push+pop
    cycle(1, 32'h0, $urandom, 1, 0);
    for (int k = 1; k < 10; k++) begin
      cycle(1, 32'(4 * k), $urandom, 1, 0);
      check("t4_count", 64'(bus.count), 64'd1);
    end
    cycle(0, 0, 0, 1, 0);
    // flush with a pending push
    cycle(1, 32'h0, 32'hAAAA_0000, 0, 0);
    cycle(1, 32'h4, 32'hBBBB_0004, 0, 0);
    cycle(1, 32'h40, 32'hCCCC_0040, 0, 1);
    check("t5_count", 64'(bus.count), 64'd0);
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    cycle(1, 32'h0, 32'hAAAA_0000, 0, 0);
    cycle(1, 32'h40, 32'hCCCC_0040, 1, 1);
    check("t5b_count", 64'(bus.count), 64'd0);
    cycle(0, 0, 0, 0, 0);
    // asynchronous reset mid-cycle with a full queue
    cycle(1, 32'h0, 32'hDEAD_0000, 0, 0);
    cycle(1, 32'h4, 32'hBEEF_0004, 0, 0);
    check("t1_pre_count", 64'(bus.count), 64'd2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t1_count", 64'(bus.count), 64'd0);
    check("t1_out_valid", 64'(bus.out_valid), 64'd0);
    check("t1_in_ready", 64'(bus.in_ready), 64'd1);
    check("t1_out_instr", 64'(bus.out_instr), 64'd0);
    mq.delete();
    bus.in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
